// File: rtl/fsm_step_ctrl_pkg.sv
// Shared types and defaults for the step controller that drives the paired
// sequence-detector FSMs.
package fsm_step_ctrl_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
   localparam int unsigned PATTERN_LEN_DEF     = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READY = 3'd1,
      PULSE = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } stepState_t;

   // True while a pattern is being played back.
   function automatic logic isPlaying(input stepState_t s);
      return (s == READY) || (s == PULSE) || (s == CHECK);
   endfunction

   // A new pattern may only be taken when no playback is in progress.
   function automatic logic canLoad(input stepState_t s);
      return (s == IDLE) || (s == DONE);
   endfunction

endpackage

// File: rtl/fsm_step_ctrl_btn_debounce.sv
// Button debouncer: 2-flop synchronizer, consecutive-sample filter, and a
// one-cycle press pulse on each accepted 0->1 level change.
module btn_debounce
   import fsm_step_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic Clk,
   input  logic R,
   input  logic btn_in,
   output logic press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    syncQ;
   logic          stableQ;
   logic [CW-1:0] cntQ;

   always_ff @(posedge Clk or negedge R) begin
      if (!R) syncQ <= 2'b00;
      else    syncQ <= {syncQ[0], btn_in};
   end

   // Any sample equal to the stable level restarts the run of differing samples.
   always_ff @(posedge Clk or negedge R) begin
      if (!R) begin
         stableQ <= 1'b0;
         cntQ    <= '0;
         press   <= 1'b0;
      end else begin
         press <= 1'b0;
         if (syncQ[1] == stableQ) begin
            cntQ <= '0;
         end else if (cntQ == CW'(DEBOUNCE_CYCLES - 1)) begin
            stableQ <= ~stableQ;
            cntQ    <= '0;
            press   <= ~stableQ;
         end else begin
            cntQ <= cntQ + CW'(1);
         end
      end
   end

endmodule

// File: rtl/fsm_step_ctrl.sv
// Plays a loaded w pattern into the two detector FSMs one step at a time and
// latches the first step where their Z outputs disagree.
module fsm_step_ctrl
   import fsm_step_ctrl_pkg::*;
#(
   parameter  int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter  int unsigned PATTERN_LEN     = PATTERN_LEN_DEF,
   localparam int unsigned IW              = $clog2(PATTERN_LEN)
) (
   input  logic                   Clk,
   input  logic                   R,
   input  logic                   step_btn,
   input  logic                   run,
   input  logic                   load,
   input  logic [PATTERN_LEN-1:0] pattern,
   input  logic                   z_bin,
   input  logic                   z_onehot,
   output logic                   w,
   output logic                   step_en,
   output logic [IW-1:0]          idx,
   output logic                   busy,
   output logic                   done,
   output logic                   mismatch,
   output logic [IW-1:0]          err_idx
);

   stepState_t             stateQ, stateNext;
   logic [PATTERN_LEN-1:0] patQ;
   logic                   press;
   logic                   lastStep;
   logic                   stepEnNext, busyNext, doneNext;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .Clk    (Clk),
      .R      (R),
      .btn_in (step_btn),
      .press  (press)
   );

   assign lastStep = (idx == IW'(PATTERN_LEN - 1));

   always_ff @(posedge Clk or negedge R) begin
      if (!R) stateQ <= IDLE;
      else    stateQ <= stateNext;
   end

   always_comb begin
      stateNext = stateQ;
      case (stateQ)
         IDLE, DONE: if (load)          stateNext = READY;
         READY:      if (press || run)  stateNext = PULSE;
         PULSE:                         stateNext = CHECK;
         CHECK:                         stateNext = lastStep ? DONE : READY;
         default:                       stateNext = IDLE;
      endcase
   end

   // Flag outputs are decoded from the next state so they register alongside it.
   always_comb begin
      stepEnNext = (stateNext == PULSE);
      busyNext   = isPlaying(stateNext);
      doneNext   = (stateNext == DONE);
      w          = 1'b0;
      if (isPlaying(stateQ)) w = patQ[idx];
   end

   always_ff @(posedge Clk or negedge R) begin
      if (!R) begin
         step_en <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         step_en <= stepEnNext;
         busy    <= busyNext;
         done    <= doneNext;
      end
   end

   // Pattern, step index and first-disagreement capture.
   always_ff @(posedge Clk or negedge R) begin
      if (!R) begin
         patQ     <= '0;
         idx      <= '0;
         mismatch <= 1'b0;
         err_idx  <= '0;
      end else if (canLoad(stateQ) && load) begin
         patQ     <= pattern;
         idx      <= '0;
         mismatch <= 1'b0;
         err_idx  <= '0;
      end else if (stateQ == CHECK) begin
         if ((z_bin != z_onehot) && !mismatch) begin
            mismatch <= 1'b1;
            err_idx  <= idx;
         end
         if (!lastStep) idx <= idx + IW'(1);
      end
   end

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// Scoreboard bench for fsm_step_ctrl: each accepted load queues the expected
// per-step (w, idx) stream and end-of-pattern result; a monitor consumes them.
module tb_fsm_step_ctrl;

   localparam int unsigned PL = 8;

   logic       Clk = 1'b0;
   logic       R, step_btn, run, load;
   logic [7:0] pattern;
   logic       z_bin, z_onehot;
   logic       w, step_en, busy, done, mismatch;
   logic [2:0] idx, err_idx;

   int vectors     = 0;
   int miscompares = 0;
   int stepCount   = 0;

   typedef struct packed { logic w; logic [2:0] idx; } stepExp_t;
   typedef struct packed { logic mm; logic [2:0] ei; } resExp_t;

   stepExp_t stepQ[$];
   resExp_t  resQ[$];
   stepExp_t se;
   resExp_t  re;

   fsm_step_ctrl #(.DEBOUNCE_CYCLES(4), .PATTERN_LEN(PL)) dut (
      .Clk      (Clk),
      .R        (R),
      .step_btn (step_btn),
      .run      (run),
      .load     (load),
      .pattern  (pattern),
      .z_bin    (z_bin),
      .z_onehot (z_onehot),
      .w        (w),
      .step_en  (step_en),
      .idx      (idx),
      .busy     (busy),
      .done     (done),
      .mismatch (mismatch),
      .err_idx  (err_idx)
   );

   initial forever #5 Clk = ~Clk;

   // Stand-in detector FSMs: both detect "11"; the one-hot copy can be
   // inverted for chosen step indices to provoke a disagreement.
   logic       zDet, prevW;
   logic [2:0] lastIdx;
   logic [7:0] injectMask;

   always @(posedge Clk or negedge R) begin
      if (!R) begin
         zDet    <= 1'b0;
         prevW   <= 1'b0;
         lastIdx <= 3'd0;
      end else if (step_en) begin
         zDet    <= prevW & w;
         prevW   <= w;
         lastIdx <= idx;
      end
   end

   assign z_bin    = zDet;
   assign z_onehot = zDet ^ injectMask[lastIdx];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int firstSet(input logic [7:0] m);
      for (int k = 0; k < 8; k++) if (m[k]) return k;
      return -1;
   endfunction

   // Monitor: every step_en pops one expected step; every rising done pops a result.
   logic prevDone = 1'b0;
   always @(negedge Clk) begin
      if (!R) begin
         prevDone <= 1'b0;
      end else begin
         if (step_en) begin
            stepCount <= stepCount + 1;
            if (stepQ.size() == 0) chk("unexpected_step", 32'd1, 32'd0);
            else begin
               se = stepQ.pop_front();
               chk("step_w", 32'(w), 32'(se.w));
               chk("step_idx", 32'(idx), 32'(se.idx));
            end
         end
         if (done && !prevDone) begin
            if (resQ.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
               re = resQ.pop_front();
               chk("final_mismatch", 32'(mismatch), 32'(re.mm));
               chk("final_err_idx", 32'(err_idx), 32'(re.ei));
               chk("final_idx", 32'(idx), 32'(PL - 1));
               chk("steps_left", 32'(stepQ.size()), 32'd0);
            end
         end
         prevDone <= done;
      end
   end

   // Model of an accepted load: the whole pattern is queued in order.
   task automatic expectLoad(input logic [7:0] p, input logic [7:0] mask);
      int fm;
      stepQ.delete();
      resQ.delete();
      injectMask = mask;
      for (int k = 0; k < 8; k++) stepQ.push_back('{w: p[k], idx: 3'(k)});
      fm = firstSet(mask);
      if (fm < 0) resQ.push_back('{mm: 1'b0, ei: 3'd0});
      else        resQ.push_back('{mm: 1'b1, ei: 3'(fm)});
   endtask

   task automatic issueLoad(input logic [7:0] p, input logic [7:0] mask);
      @(negedge Clk);
      pattern = p;
      load    = 1'b1;
      expectLoad(p, mask);
      @(negedge Clk);
      load = 1'b0;
   endtask

   task automatic waitDone(output int cyc);
      cyc = 0;
      while (!done && cyc < 400) begin
         @(negedge Clk);
         cyc++;
      end
      if (!done) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitStepAt(input logic [2:0] at);
      int n = 0;
      while (!(step_en && idx == at) && n < 200) begin
         @(negedge Clk);
         n++;
      end
      if (!(step_en && idx == at)) chk("step_wait_timeout", 32'd0, 32'd1);
   endtask

   task automatic pressBtn();
      step_btn = 1'b1;
      repeat (8) @(negedge Clk);
      step_btn = 1'b0;
      repeat (8) @(negedge Clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc, s0;
      logic [7:0] p, m;
      R = 1'b0; step_btn = 1'b0; run = 1'b0; load = 1'b0;
      pattern = 8'h00; injectMask = 8'h00;
      repeat (3) @(negedge Clk);
      chk("rst_w", 32'(w), 0);        chk("rst_step_en", 32'(step_en), 0);
      chk("rst_idx", 32'(idx), 0);    chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);  chk("rst_mismatch", 32'(mismatch), 0);
      chk("rst_err_idx", 32'(err_idx), 0);
      R = 1'b1;
      repeat (2) @(negedge Clk);

      // Free-run over 0000_1111 with agreeing FSMs.
      run = 1'b1;
      s0  = stepCount;
      issueLoad(8'b0000_1111, 8'h00);
      waitDone(cyc);
      chk("run_cycles", 32'(cyc), 32'd24);
      @(negedge Clk);
      chk("run_steps", 32'(stepCount - s0), 32'd8);
      chk("run_busy_done", 32'(busy), 0);

      // Forced disagreement at idx 5 and 6: first one latched and kept in DONE.
      issueLoad(8'($urandom), 8'h60);
      waitDone(cyc);
      chk("mm_cycles", 32'(cyc), 32'd24);
      repeat (5) @(negedge Clk);
      chk("mm_persist", 32'(mismatch), 1);
      chk("err_persist", 32'(err_idx), 5);
      chk("done_persist", 32'(done), 1);

      // Random patterns and disagreement masks.
      for (int t = 0; t < 4; t++) begin
         p = 8'($urandom);
         m = 8'($urandom) & 8'($urandom) & 8'($urandom);
         issueLoad(p, m);
         waitDone(cyc);
         chk("rand_cycles", 32'(cyc), 32'd24);
      end

      // Manual stepping with a bouncing button.
      run = 1'b0;
      issueLoad(8'($urandom), 8'h00);
      repeat (3) @(negedge Clk);
      chk("btn_busy_ready", 32'(busy), 1);
      chk("btn_no_step_yet", 32'(idx), 0);
      s0 = stepCount;
      for (int b = 0; b < 4; b++) begin
         step_btn = (b % 2 == 0);
         @(negedge Clk);
      end
      step_btn = 1'b1;
      repeat (6) @(negedge Clk);
      repeat (6) @(negedge Clk);
      chk("btn_one_step", 32'(stepCount - s0), 1);
      chk("btn_idx1", 32'(idx), 1);
      step_btn = 1'b0;
      repeat (12) @(negedge Clk);
      chk("btn_release_no_step", 32'(stepCount - s0), 1);
      for (int k = 0; k < 7; k++) pressBtn();
      waitDone(cyc);
      chk("btn_steps", 32'(stepCount - s0), 8);

      // Free-run with random button activity: presses never add steps.
      run = 1'b1;
      s0  = stepCount;
      issueLoad(8'($urandom), 8'($urandom) & 8'($urandom));
      for (int k = 0; k < 40; k++) begin
         step_btn = 1'($urandom_range(0, 1));
         repeat (5) @(negedge Clk);
      end
      step_btn = 1'b0;
      repeat (12) @(negedge Clk);
      chk("runbtn_done", 32'(done), 1);
      chk("runbtn_steps", 32'(stepCount - s0), 8);

      // Load during PULSE is ignored; load in DONE restarts cleanly.
      p = 8'($urandom);
      issueLoad(p, 8'h04);
      waitStepAt(3'd2);
      pattern = ~p;
      load    = 1'b1;
      @(negedge Clk);
      load = 1'b0;
      chk("ignored_load_idx", 32'(idx), 2);
      chk("ignored_load_busy", 32'(busy), 1);
      waitDone(cyc);
      @(negedge Clk);
      chk("pre_reload_mm", 32'(mismatch), 1);
      issueLoad(8'($urandom), 8'h00);
      chk("reload_idx", 32'(idx), 0);
      chk("reload_done", 32'(done), 0);
      chk("reload_mm", 32'(mismatch), 0);
      chk("reload_busy", 32'(busy), 1);
      waitDone(cyc);

      // Asynchronous reset while in CHECK at idx 3.
      issueLoad(8'hFF, 8'h01);
      waitStepAt(3'd3);
      @(posedge Clk);
      #2;
      R = 1'b0;
      #1;
      chk("arst_w", 32'(w), 0);        chk("arst_step_en", 32'(step_en), 0);
      chk("arst_idx", 32'(idx), 0);    chk("arst_busy", 32'(busy), 0);
      chk("arst_done", 32'(done), 0);  chk("arst_mismatch", 32'(mismatch), 0);
      chk("arst_err_idx", 32'(err_idx), 0);
      stepQ.delete();
      resQ.delete();
      @(negedge Clk);
      R = 1'b1;
      repeat (10) @(negedge Clk);
      chk("post_rst_idle_busy", 32'(busy), 0);
      chk("post_rst_idle_done", 32'(done), 0);
      issueLoad(8'($urandom), 8'h80);
      waitDone(cyc);
      chk("post_rst_cycles", 32'(cyc), 32'd24);

      repeat (3) @(negedge Clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fsm_step_ctrl.md
Name: fsm_step_ctrl

Overview:
- Sequencer for the paired sequence-detector FSMs (binary-encoded and one-hot), which share one `w` input and each drive one `Z` output.
- Plays back a loaded `w` test pattern one bit per step, from either a debounced step button or free-run mode.
- Issues a one-cycle step enable that the FSMs use as their clock enable.
- Cross-checks the two `Z` outputs after every step and latches the first disagreement.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive synchronized samples needed to accept a button level change (minimum 2).
- PATTERN_LEN, 8: number of `w` bits per pattern (minimum 2); IW = $clog2(PATTERN_LEN).

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- R  in  1  reset, asynchronous, active-low.
- step_btn  in  1  raw, asynchronous step pushbutton.
- run  in  1  free-run mode; level-sensitive.
- load  in  1  one-cycle load strobe.
- pattern  in  PATTERN_LEN  w sequence; bit 0 is applied first.
- z_bin  in  1  Z from the binary-encoded FSM.
- z_onehot  in  1  Z from the one-hot FSM.
- w  out  1  w bit currently driven to both FSMs.
- step_en  out  1  one-cycle clock enable to both FSMs.
- idx  out  IW  index of the current pattern bit.
- busy  out  1  pattern playback in progress.
- done  out  1  whole pattern applied.
- mismatch  out  1  sticky flag: z_bin != z_onehot was seen.
- err_idx  out  IW  idx at which the first mismatch occurred.

Behaviour:
- Reset (R low, asynchronous):
  - state=IDLE; w, step_en, idx, busy, done, mismatch, err_idx all 0.
  - Pattern register and debounce state cleared.
  - Reset mid-pattern abandons the run; no partial result is kept.
- Debounce sub-block:
  - step_btn passes through a 2-flop synchronizer.
  - A counter counts consecutive cycles where the synchronized value differs from the stable value; any equal cycle clears the counter.
  - After DEBOUNCE_CYCLES consecutive differing samples, stable toggles and the counter clears.
  - `press` is a registered one-cycle pulse on each stable 0->1 transition. Release generates nothing.
- States:
  - IDLE: busy=0, done=0. On load: pat_q<=pattern, idx<=0, mismatch<=0, err_idx<=0, go to READY.
  - READY: busy=1. Trigger = press OR run. On trigger go to PULSE. With run=1 there is no wait in READY.
  - PULSE: step_en=1 for exactly this cycle, then go to CHECK.
  - CHECK: step_en=0; FSM outputs now reflect the step.
    - If z_bin != z_onehot and mismatch==0: mismatch<=1, err_idx<=idx.
    - If idx==PATTERN_LEN-1, go to DONE. Otherwise idx<=idx+1 and go to READY.
  - DONE: busy=0, done=1; idx holds PATTERN_LEN-1. On load, behave exactly as load in IDLE (done<=0).
- w drive:
  - w = pat_q[idx] combinationally in READY, PULSE and CHECK, so w is stable for at least one cycle before and after step_en.
  - w=0 in IDLE and DONE.
- Free-run timing: 3 cycles per step; a full pattern takes 3*PATTERN_LEN cycles from leaving IDLE.
- Boundary conditions:
  - load in READY, PULSE or CHECK is ignored.
  - press in IDLE, PULSE, CHECK or DONE is dropped, not queued.
  - press and run together in READY cause a single step.
  - Dropping run mid-pattern: the step in flight completes, then the block waits in READY for press.
  - mismatch and err_idx persist through DONE until the next load or reset.
  - idx never wraps; the last step always goes to DONE.

Decomposition:
- Shared package holds:
  - State enum: IDLE=0, READY=1, PULSE=2, CHECK=3, DONE=4 (3-bit).
  - Default constants DEBOUNCE_CYCLES_DEF=16 and PATTERN_LEN_DEF=8.
- One natural sub-module, btn_debounce(Clk, R, btn_in, press), parameterized by DEBOUNCE_CYCLES; it is reusable for other board buttons.
- The top-level board wrapper instantiates fsm_step_ctrl and routes step_en/w to both FSMs.

Test Plan (PATTERN_LEN=8, DEBOUNCE_CYCLES=4):
- Reset, then load with pattern=8'b0000_1111, run=1, with model FSMs that agree -> exactly 8 step_en pulses, 3 cycles apart; w sequence 1,1,1,1,0,0,0,0; done=1 at cycle 24; mismatch=0.
- Same run, but force z_onehot inverted only after the step with idx=5 -> mismatch=1 and err_idx=5; both unchanged after a further forced mismatch at idx=6.
- run=0, step_btn bouncing (1,0,1,0, then held 1 for 6 cycles) -> exactly one step_en; idx goes 0->1; releasing the button gives no step.
- load asserted during PULSE -> ignored; pat_q and idx unchanged; load in DONE restarts with idx=0, done=0 and mismatch cleared.
- R pulled low while idx=3 in CHECK -> all outputs 0 immediately (asynchronously); after release the block sits in IDLE until load.
- press coincident with run=1 in READY -> one step_en only; a press arriving during CHECK is dropped, so the step_en count equals the number of READY-state triggers.
